// File: rtl/cfg_loader_pkg.sv
// cfg_loader_pkg
// Shared definitions for the configuration-frame loader: the loader FSM
// state encoding and the bit-counter width helper.
package cfg_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // Counter must be able to hold the value n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/config_frame_loader_if.sv
// config_frame_loader_if
// Serial configuration-chain bundle between a chain driver (master) and a
// frame loader (slave).
//   frame_start      master->slave  synchronous pulse, begins a new frame
//   ccff_head        master->slave  serial data/parity bit
//   ccff_valid       master->slave  qualifies ccff_head
//   ccff_tail        slave->master  bit shifted out of the chain end
//   ccff_tail_valid  slave->master  qualifies ccff_tail
interface config_frame_loader_if;
  logic frame_start;
  logic ccff_head;
  logic ccff_valid;
  logic ccff_tail;
  logic ccff_tail_valid;

  modport master (
    output frame_start, ccff_head, ccff_valid,
    input  ccff_tail, ccff_tail_valid
  );

  modport slave (
    input  frame_start, ccff_head, ccff_valid,
    output ccff_tail, ccff_tail_valid
  );
endinterface

// File: rtl/cfg_shift_reg.sv
// cfg_shift_reg
// NUM_MEM-bit serial-in/parallel-out shift register with a running even
// parity of every bit shifted in since the last clear.
//   clk_i       programming clock
//   rst_ni      asynchronous active-low reset
//   clr_i       clears the running parity (frame start)
//   shift_en_i  shift sin_i into bit 0
//   sin_i       serial input
//   pout_o      parallel contents
//   msb_o       current MSB, i.e. the bit leaving the chain on this shift
//   par_o       XOR of all bits shifted in since clr_i
module cfg_shift_reg #(
  parameter int NUM_MEM = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               shift_en_i,
  input  logic               sin_i,
  output logic [NUM_MEM-1:0] pout_o,
  output logic               msb_o,
  output logic               par_o
);

  logic [NUM_MEM-1:0] sr_q, sr_d;
  logic               par_q, par_d;

  // The register contents survive a clear; only the parity restarts.
  always_comb begin
    sr_d  = sr_q;
    par_d = par_q;
    if (clr_i) begin
      par_d = 1'b0;
    end else if (shift_en_i) begin
      sr_d  = {sr_q[NUM_MEM-2:0], sin_i};
      par_d = par_q ^ sin_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q  <= '0;
      par_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      par_q <= par_d;
    end
  end

  assign pout_o = sr_q;
  assign msb_o  = sr_q[NUM_MEM-1];
  assign par_o  = par_q;

endmodule

// File: rtl/config_frame_loader.sv
// config_frame_loader
// Loads a frame of NUM_MEM configuration bits plus one even-parity bit from
// the serial chain and, only when parity matches, commits the whole frame
// at once to complementary memory-bit outputs for mux-tree / LUT cells.
//   prog_clk   programming clock (rising edge)
//   pReset_n   asynchronous active-low reset
//   chain      serial chain bundle (frame_start, ccff_head/valid in;
//              ccff_tail/valid out for daisy-chaining)
//   mem_out    committed configuration bits
//   mem_outb   registered complement of mem_out
//   busy       frame in progress (SHIFT, PARITY, COMMIT)
//   cfg_done   one-cycle pulse after a successful commit
//   cfg_error  sticky parity failure, cleared by frame_start
module config_frame_loader
  import cfg_loader_pkg::*;
#(
  parameter int NUM_MEM = 16
) (
  input  logic                  prog_clk,
  input  logic                  pReset_n,
  config_frame_loader_if.slave  chain,
  output logic [NUM_MEM-1:0]    mem_out,
  output logic [NUM_MEM-1:0]    mem_outb,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  cfg_error
);

  localparam int             CW   = cnt_width(NUM_MEM);
  localparam logic [CW-1:0]  LAST = CW'(NUM_MEM - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_MEM-1:0] mem_q, mem_d;
  logic [NUM_MEM-1:0] memb_q, memb_d;
  logic               tail_q, tail_d;
  logic               tailv_q, tailv_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               shift_en;
  logic [NUM_MEM-1:0] sr;
  logic               sr_msb;
  logic               sr_par;

  cfg_shift_reg #(.NUM_MEM(NUM_MEM)) u_sr (
    .clk_i      (prog_clk),
    .rst_ni     (pReset_n),
    .clr_i      (chain.frame_start),
    .shift_en_i (shift_en),
    .sin_i      (chain.ccff_head),
    .pout_o     (sr),
    .msb_o      (sr_msb),
    .par_o      (sr_par)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    memb_d   = memb_q;
    tail_d   = tail_q;
    tailv_d  = 1'b0;
    err_d    = err_q;
    shift_en = 1'b0;
    // COMMIT always completes, even when a new frame_start arrives with it.
    done_d   = (state_q == COMMIT);
    if (state_q == COMMIT) begin
      mem_d  = sr;
      memb_d = ~sr;
    end

    if (chain.frame_start) begin
      // Restart wins over any bit presented in the same cycle.
      state_d = SHIFT;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        SHIFT: begin
          if (chain.ccff_valid) begin
            shift_en = 1'b1;
            cnt_d    = cnt_q + 1'b1;
            tail_d   = sr_msb;
            tailv_d  = 1'b1;
            if (cnt_q == LAST) state_d = PARITY;
          end
        end
        PARITY: begin
          if (chain.ccff_valid) begin
            if (chain.ccff_head == sr_par) begin
              state_d = COMMIT;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end
        COMMIT:  state_d = IDLE;
        default: ;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mem_q   <= '0;
      memb_q  <= '1;
      tail_q  <= 1'b0;
      tailv_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
      memb_q  <= memb_d;
      tail_q  <= tail_d;
      tailv_q <= tailv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_out               = mem_q;
  assign mem_outb              = memb_q;
  assign busy                  = busy_q;
  assign cfg_done              = done_q;
  assign cfg_error             = err_q;
  assign chain.ccff_tail       = tail_q;
  assign chain.ccff_tail_valid = tailv_q;

endmodule

// File: tb/tb_config_frame_loader.sv
// tb_config_frame_loader
// Scoreboard bench: stimulus pushes expected commits and expected tail bits;
// a monitor on the falling edge pops and compares whenever the loader
// presents cfg_done or ccff_tail_valid.
module tb_config_frame_loader;
  localparam int N = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  config_frame_loader_if chain();
  logic [N-1:0] mem_out, mem_outb;
  logic         busy, cfg_done, cfg_error;

  config_frame_loader #(.NUM_MEM(N)) dut (
    .prog_clk  (clk),
    .pReset_n  (rst_n),
    .chain     (chain),
    .mem_out   (mem_out),
    .mem_outb  (mem_outb),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .cfg_error (cfg_error)
  );

  int total = 0;
  int bad   = 0;
  int dones = 0;

  logic [N-1:0] exp_done_q[$];
  logic         exp_tail_q[$];
  logic [N-1:0] sr_m = '0;
  logic [N-1:0] e_mem, e_memb;
  logic         e_tail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      chk("outb_complement", mem_outb ^ mem_out, 32'h0000FFFF);
      if (cfg_done) begin
        dones++;
        if (exp_done_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got commit of %h expected none", mem_out);
        end else begin
          e_mem  = exp_done_q.pop_front();
          e_memb = ~e_mem;
          chk("commit_mem_out", mem_out, e_mem);
          chk("commit_mem_outb", mem_outb, e_memb);
        end
      end
      if (chain.ccff_tail_valid) begin
        if (exp_tail_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_tail: got bit %b expected none", chain.ccff_tail);
        end else begin
          e_tail = exp_tail_q.pop_front();
          chk("tail_bit", chain.ccff_tail, e_tail);
        end
      end
    end
  end

  task automatic cyc(input logic fs, input logic v, input logic h);
    @(negedge clk);
    chain.frame_start = fs;
    chain.ccff_valid  = v;
    chain.ccff_head   = h;
  endtask

  task automatic send_bit(input logic b);
    cyc(1'b0, 1'b1, b);
    exp_tail_q.push_back(sr_m[N-1]);
    sr_m = {sr_m[N-2:0], b};
  endtask

  task automatic send_data(input logic [N-1:0] w, input bit gapped);
    for (int i = N - 1; i >= 0; i--) begin
      send_bit(w[i]);
      if (gapped) cyc(1'b0, 1'b0, 1'($urandom));
    end
  endtask

  task automatic frame(input logic [N-1:0] w, input logic par, input bit gapped);
    cyc(1'b1, 1'b1, 1'($urandom));
    send_data(w, gapped);
    cyc(1'b0, 1'b1, par);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    chain.frame_start = 1'b0;
    chain.ccff_valid  = 1'b0;
    chain.ccff_head   = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_out", mem_out, 16'h0000);
    chk("rst_mem_outb", mem_outb, 16'hFFFF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_error", cfg_error, 1'b0);
    chk("rst_tail_valid", chain.ccff_tail_valid, 1'b0);
    rst_n = 1'b1;

    // Idle cycles with random valid must not disturb anything.
    repeat (5) cyc(1'b0, 1'($urandom), 1'($urandom));
    cyc(1'b0, 1'b0, 1'b0);
    chk("idle_mem_out", mem_out, 16'h0000);
    chk("idle_busy", busy, 1'b0);

    // Good frame 0xA5C3, parity 0
    exp_done_q.push_back(16'hA5C3);
    frame(16'hA5C3, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("good_commit_cycle_done", cfg_done, 1'b0);
    chk("good_commit_cycle_mem", mem_out, 16'h0000);
    chk("good_commit_cycle_busy", busy, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("good_done", cfg_done, 1'b1);
    chk("good_mem_out", mem_out, 16'hA5C3);
    chk("good_mem_outb", mem_outb, 16'h5A3C);
    chk("good_error", cfg_error, 1'b0);
    chk("good_busy", busy, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("good_done_single", cfg_done, 1'b0);

    // Same frame, wrong parity
    frame(16'hA5C3, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("bad_error", cfg_error, 1'b1);
    chk("bad_busy", busy, 1'b0);
    chk("bad_mem_hold", mem_out, 16'hA5C3);
    cyc(1'b0, 1'b0, 1'b0);
    chk("bad_no_done", cfg_done, 1'b0);
    chk("bad_error_sticky", cfg_error, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("restart_clears_error", cfg_error, 1'b0);
    chk("restart_busy", busy, 1'b1);

    // Gapped 0xFFFF; tail stream is the 0xA5C3 still in the chain
    exp_done_q.push_back(16'hFFFF);
    frame(16'hFFFF, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("gap_done", cfg_done, 1'b1);
    chk("gap_mem_out", mem_out, 16'hFFFF);

    // Abort after 7 bits, then 0x0001 with parity 1
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    exp_done_q.push_back(16'h0001);
    frame(16'h0001, 1'b1, 1'b0);
    chk("abort_no_error", cfg_error, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("abort_done", cfg_done, 1'b1);
    chk("abort_mem_out", mem_out, 16'h0001);
    chk("abort_error", cfg_error, 1'b0);

    // Reset while waiting for the parity bit
    cyc(1'b1, 1'b0, 1'b0);
    send_data(16'h1234, 1'b0);
    @(negedge clk);
    chain.ccff_valid = 1'b1;
    chain.ccff_head  = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_out", mem_out, 16'h0000);
    chk("async_rst_mem_outb", mem_outb, 16'hFFFF);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_tail_valid", chain.ccff_tail_valid, 1'b0);
    sr_m = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    chk("post_rst_mem_out", mem_out, 16'h0000);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_error", cfg_error, 1'b0);

    chk("pending_commits", exp_done_q.size(), 0);
    chk("pending_tails", exp_tail_q.size(), 0);
    chk("done_pulses", dones, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
